// File: rtl/program_counter_pkg.sv
// program_counter_pkg: fetch-stage PC constants and the address type
package program_counter_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] addr_t;
  localparam addr_t RESET_VECTOR = 32'h0000_0000;
  localparam addr_t PC_STEP = 32'd4;
  localparam int IMM_SHIFT = 1;
endpackage

// File: rtl/program_counter_if.sv
// program_counter_if: fetch control in, current instruction address out
interface program_counter_if;
  import program_counter_pkg::*;
  logic en;
  logic jmp;
  addr_t imm;
  addr_t pc_out;
  modport master (output en, jmp, imm, input pc_out);
  modport slave (input en, jmp, imm, output pc_out);
endinterface

// File: rtl/program_counter_next_calc.sv
// program_counter_next_calc: picks sequential step or pc-relative target
module program_counter_next_calc
  import program_counter_pkg::*;
(
  input  addr_t i_pc,
  input  logic  i_jmp,
  input  addr_t i_imm,
  output addr_t o_next
);
  addr_t w_off;
  // imm is a signed halfword offset; the shift truncates to XLEN and the add wraps
  always_comb begin
    w_off = addr_t'($signed(i_imm) <<< IMM_SHIFT);
    o_next = i_jmp ? i_pc + w_off : i_pc + PC_STEP;
  end
endmodule

// File: rtl/program_counter.sv
// program_counter: fetch-stage PC register with reset/stall priority
module program_counter
  import program_counter_pkg::*;
(
  input logic clk,
  input logic rst,
  program_counter_if.slave bus
);
  addr_t pc_reg;
  addr_t w_next;
  program_counter_next_calc u_next_calc (
    .i_pc   (pc_reg),
    .i_jmp  (bus.jmp),
    .i_imm  (bus.imm),
    .o_next (w_next)
  );
  // reset beats everything; a stall holds the PC and ignores jmp/imm
  always_ff @(posedge clk)
    if (rst) pc_reg <= RESET_VECTOR;
    else if (bus.en) pc_reg <= w_next;
  assign bus.pc_out = pc_reg;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed vectors with hand-computed PC values
module tb_program_counter;
  import program_counter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  program_counter_if bus ();
  program_counter dut (.clk(clk), .rst(rst), .bus(bus));
  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;
  task automatic check(input string tag, input addr_t exp);
    n_vec++;
    assert (bus.pc_out === exp)
    else begin
      n_err++;
      $error("FAIL %s: pc_out=%h expected %h", tag, bus.pc_out, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic e, input logic j, input addr_t im, input addr_t exp);
    rst = r;
    bus.en = e;
    bus.jmp = j;
    bus.imm = im;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask
  // stimulus runs just after each rising edge; checks land at posedge+1
  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.jmp = 1'b0;
    bus.imm = '0;
    @(posedge clk);
    #1;
    check("reset", 32'd0);
    step("inc_4", 1'b0, 1'b1, 1'b0, 32'd0, 32'd4);
    step("inc_8", 1'b0, 1'b1, 1'b0, 32'd0, 32'd8);
    step("stall_1", 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
    step("stall_2", 1'b0, 1'b0, 1'b1, 32'd7, 32'd8);
    step("jmp_pos", 1'b0, 1'b1, 1'b1, 32'd4, 32'd16);
    step("jmp_neg", 1'b0, 1'b1, 1'b1, -32'sd2, 32'd12);
    step("stall_jmp", 1'b0, 1'b0, 1'b1, 32'd10, 32'd12);
    step("jmp_odd_1", 1'b0, 1'b1, 1'b1, 32'd1, 32'd14);
    step("jmp_odd_2", 1'b0, 1'b1, 1'b1, 32'd1, 32'd16);
    bus.en = 1'b1;
    bus.jmp = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_not_async", 32'd16);
    @(negedge clk);
    check("rst_pre_edge", 32'd16);
    @(posedge clk);
    #1;
    check("rst_mid", 32'd0);
    step("post_rst_inc", 1'b0, 1'b1, 1'b0, 32'd0, 32'd4);
    step("jmp_wrap_neg", 1'b0, 1'b1, 1'b1, -32'sd4, 32'hFFFF_FFFC);
    dut.pc_reg = 32'hFFFF_FFF0;
    #1;
    check("preload_jmp", 32'hFFFF_FFF0);
    step("jmp_wrap_pos", 1'b0, 1'b1, 1'b1, 32'd8, 32'd0);
    step("jmp_trunc", 1'b0, 1'b1, 1'b1, 32'h8000_0001, 32'd2);
    dut.pc_reg = 32'hFFFF_FFFC;
    #1;
    check("preload_seq", 32'hFFFF_FFFC);
    step("seq_wrap", 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    step("inc_again", 1'b0, 1'b1, 1'b0, 32'd0, 32'd4);
    step("priority", 1'b1, 1'b1, 1'b1, 32'd100, 32'd0);
    step("stall_rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
